// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding and parity mode codes.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..divisor-1 and ticks on the last count.
// Held at zero while start is high so the first period is full length.
module uart_baud_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] divisor,
    input  logic        start,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic        wrap;

    assign wrap = (cnt_q == divisor - 32'd1);
    assign tick = wrap && !start;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (start || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter; frame format and rate latched per frame.
// Optional parity support is built when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned DATA_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           baud_rate,
    input  logic [3:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  cfg_err
);

    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           bcnt_q, bcnt_d;
    logic [3:0]            bits_q, bits_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  two_q, two_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  err_q, err_d;
    logic                  rdy_q;
    logic                  tick, done, accept, illegal;
    logic [31:0]           div_calc;

    assign div_calc = (baud_rate == 32'd0) ? 32'd0
                    : 32'(CLOCK_FREQUENCY) / baud_rate;
    assign illegal  = (baud_rate == 32'd0) || (div_calc < 32'd2)
                   || (data_bits < 4'd5) || (data_bits > DW4);

    // in_ready stays low for one cycle after reset and on illegal offers
    assign in_ready = rdy_q && (state_q == IDLE) && !(in_valid && illegal);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign tx_done  = done;
    assign tx_out   = tx_q;
    assign cfg_err  = err_q;

    uart_baud_gen u_baud (
        .clk     (clk),
        .reset   (reset),
        .divisor (div_q),
        .start   (state_q == IDLE),
        .tick    (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_q, par_d;
    logic par_calc;

    always_comb begin
        par_calc = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(data_bits)) begin
                par_calc = par_calc ^ data_in[i];
            end
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bcnt_d  = bcnt_q;
        bits_d  = bits_q;
        sh_d    = sh_q;
        two_d   = two_q;
        stop2_d = stop2_q;
        tx_d    = tx_q;
        err_d   = err_q;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d = par_en_q;
        par_d    = par_q;
`endif
        if (rdy_q && (state_q == IDLE) && in_valid && illegal) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    sh_d    = data_in;
                    div_d   = div_calc;
                    bits_d  = data_bits;
                    two_d   = two_stop;
                    bcnt_d  = '0;
                    stop2_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_d = (parity_mode == PAR_EVEN)
                            || (parity_mode == PAR_ODD);
                    par_d    = (parity_mode == PAR_ODD) ? ~par_calc : par_calc;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bcnt_q == 32'(bits_q) - 32'd1) begin
                        bcnt_d  = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end
`endif
                    end else begin
                        bcnt_d = bcnt_q + 32'd1;
                        tx_d   = sh_q[0];
                        sh_d   = sh_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bcnt_q  <= '0;
            bits_q  <= '0;
            sh_q    <= '0;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q <= par_en_d;
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg at 1 MHz / 100 kbit/s (10 clocks per bit).
module tb_uart_tx_cfg;

    localparam int CLK_HZ = 1000000;
    localparam int DW     = 8;
    localparam int DIV    = 10;
    localparam int BAUD   = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   baud_rate;
    logic [3:0]    data_bits;
    logic [1:0]    parity_mode;
    logic          two_stop;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic          tx_out;
    logic          busy;
    logic          tx_done;
    logic          cfg_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_q[$];
    int len_q[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_rate   (baud_rate),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_out      (tx_out),
        .busy        (busy),
        .tx_done     (tx_done),
        .cfg_err     (cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected line level per bit period of one frame
    task automatic push_frame(input logic [DW-1:0] d, input int nb,
                              input int pm, input bit two);
        bit p;
        int n;
        p = 1'b0;
        n = 1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
            n++;
        end
`ifdef UART_TX_PARITY_EN
        if (pm == 1) begin
            exp_q.push_back(p);
            n++;
        end else if (pm == 2) begin
            exp_q.push_back(!p);
            n++;
        end
`else
        if (pm > 3) n = 0;
`endif
        exp_q.push_back(1'b1);
        n++;
        if (two) begin
            exp_q.push_back(1'b1);
            n++;
        end
        len_q.push_back(n);
    endtask

    task automatic drive(input logic [DW-1:0] d, input int nb,
                         input int pm, input bit two);
        baud_rate   = BAUD;
        data_in     = d;
        data_bits   = 4'(nb);
        parity_mode = 2'(pm);
        two_stop    = two;
        in_valid    = 1'b1;
        push_frame(d, nb, pm, two);
    endtask

    task automatic wait_accept(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                got = 1'b1;
                step();
                break;
            end
            step();
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s accept: in_ready stayed 0, required 1", name);
        end
    endtask

    // Called in the first cycle after the accepting edge
    task automatic check_frame(input string name);
        int nb;
        int tot;
        bit e;
        e  = 1'b1;
        nb = (len_q.size() > 0) ? len_q.pop_front() : 0;
        tot = nb * DIV;
        for (int c = 1; c <= tot; c++) begin
            if ((c - 1) % DIV == 0) e = exp_q.pop_front();
            n_chk++;
            if (tx_out !== e) begin
                n_fail++;
                $display("FAIL %s tx_out cyc %0d: got %b exp %b", name, c, tx_out, e);
            end
            n_chk++;
            if (tx_done !== (c == tot)) begin
                n_fail++;
                $display("FAIL %s tx_done cyc %0d: got %b exp %b", name, c, tx_done, c == tot);
            end
            n_chk++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy cyc %0d: got %b exp 1", name, c, busy);
            end
            step();
        end
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || tx_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: busy=%b in_ready=%b tx_out=%b exp 0/1/1",
                     name, busy, in_ready, tx_out);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        baud_rate   = BAUD;
        data_bits   = 4'd8;
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        data_in     = '0;
        #2;
        n_chk++;
        if ({tx_out, in_ready, busy, tx_done, cfg_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset outs: got %b exp 10000",
                     {tx_out, in_ready, busy, tx_done, cfg_err});
        end
        step();
        step();
        reset = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready_pre: got %b exp 0", in_ready);
        end
        step();
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_post: got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic();
        drive(8'hA5, 8, 0, 1'b0);
        wait_accept("basic");
        in_valid  = 1'b0;
        data_in   = 8'h00;
        data_bits = 4'd5;
        two_stop  = 1'b1;
        check_frame("basic");
    endtask

    task automatic test_parity();
`ifdef UART_TX_PARITY_EN
        drive(8'hA5, 8, 1, 1'b0);
        wait_accept("even");
        in_valid = 1'b0;
        check_frame("even");
        drive(8'hA5, 8, 2, 1'b0);
        wait_accept("odd");
        in_valid = 1'b0;
        check_frame("odd");
`else
        drive(8'hA5, 8, 1, 1'b0);
        wait_accept("nopar");
        in_valid = 1'b0;
        check_frame("nopar");
`endif
    endtask

    task automatic test_short();
        logic [DW-1:0] tbl [3] = '{8'h1F, 8'hEA, 8'h60};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i], 5 + i, 0, (i != 1));
            wait_accept("short");
            in_valid = 1'b0;
            check_frame("short");
        end
    endtask

    task automatic test_back_to_back();
        drive(8'hA5, 8, 0, 1'b0);
        wait_accept("b2b_a");
        drive(8'h3C, 8, 0, 1'b0);
        check_frame("b2b_a");
        step();
        in_valid = 1'b0;
        check_frame("b2b_b");
    endtask

    task automatic test_reset_mid();
        drive(8'h55, 8, 0, 1'b0);
        wait_accept("rstmid");
        in_valid = 1'b0;
        for (int c = 1; c < 37; c++) step();
        reset = 1'b1;
        #1;
        n_chk++;
        if ({tx_out, busy, tx_done, in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid outs: got %b exp 1000",
                     {tx_out, busy, tx_done, in_ready});
        end
        exp_q.delete();
        len_q.delete();
        step();
        step();
        reset = 1'b0;
        step();
        drive(8'hC3, 8, 0, 1'b1);
        wait_accept("rstmid_new");
        in_valid = 1'b0;
        check_frame("rstmid_new");
    endtask

    task automatic test_cfg_err();
        n_chk++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_init: got %b exp 0", cfg_err);
        end
        baud_rate = 32'd0;
        data_bits = 4'd8;
        data_in   = 8'h11;
        in_valid  = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_baud0 ready: got %b exp 0", in_ready);
        end
        step();
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_baud0: err=%b busy=%b tx=%b exp 1/0/1",
                     cfg_err, busy, tx_out);
        end
        baud_rate = BAUD;
        data_bits = 4'd10;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_bits10 ready: got %b exp 0", in_ready);
        end
        step();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_bits10 busy: got %b exp 0", busy);
        end
        baud_rate = 32'd600000;
        data_bits = 4'd8;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_div1 ready: got %b exp 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        step();
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_sticky: err=%b busy=%b exp 1/0", cfg_err, busy);
        end
        drive(8'h81, 8, 0, 1'b0);
        wait_accept("cfg_ok");
        in_valid = 1'b0;
        check_frame("cfg_ok");
        n_chk++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_hold: got %b exp 1", cfg_err);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_clear: got %b exp 0", cfg_err);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_short();
        test_back_to_back();
        test_reset_mid();
        test_cfg_err();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
